// File: rtl/svi_sched_pkg.sv
// Shared types and helpers for the SVI array write scheduler.
package svi_sched_pkg;

  localparam int unsigned SIZE_DEF = 8;
  localparam int unsigned CNT_W    = 4;

  function automatic int unsigned idx_w(input int unsigned size);
    return (size > 1) ? int'($clog2(size)) : 1;
  endfunction

  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } xyz_t;

  typedef enum logic {
    IDLE = 1'b0,
    COOL = 1'b1
  } sched_state_t;

endpackage

// File: rtl/svi_if.sv
// Simple interface instance carrying one {x,y,z} entry.
interface svi_if;
  logic x;
  logic y;
  logic z;
endinterface

// File: rtl/svi_array_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_c
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = PW'((32'(ptr) + i) % N);
      if (!found && req[j]) begin
        gnt_c[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svi_array_write_sched.sv
// Round-robin write scheduler sharing one registered write port over an array of svi_if entries.
// Optional write counter output o_wr_cnt when SVI_SCHED_STATS_EN is defined.
module svi_array_write_sched
  import svi_sched_pkg::*;
#(
  parameter  int unsigned SIZE        = SIZE_DEF,
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned COOL_CYCLES = 1,
  localparam int unsigned IDX_W       = idx_w(SIZE)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [N_REQ-1:0][IDX_W-1:0]  i_idx,
  input  xyz_t [N_REQ-1:0]             i_xyz,
  output logic [N_REQ-1:0]             o_gnt,
  output logic                         o_busy,
  output logic                         o_err,
  output logic [SIZE-1:0]              o_x,
  output logic [SIZE-1:0]              o_y,
  output logic [SIZE-1:0]              o_z
`ifdef SVI_SCHED_STATS_EN
  ,
  output logic [15:0]                  o_wr_cnt
`endif
);

  localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned LAST = N_REQ - 1;

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [N_REQ-1:0] elig_c, win_c;
  logic [IDX_W-1:0] win_idx;
  xyz_t             win_xyz;
  logic             idx_ok, do_grant, do_wr;
  xyz_t             ent [SIZE];

  // A requester still seeing its grant is masked so a held request is not re-served.
  assign elig_c = i_req & ~o_gnt;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (elig_c),
    .ptr   (ptr),
    .gnt_c (win_c)
  );

  // Select the winner's payload and the pointer slot just past it.
  always_comb begin
    win_idx = '0;
    win_xyz = '0;
    ptr_nxt = ptr;
    for (int unsigned r = 0; r < N_REQ; r++) begin
      if (win_c[r]) begin
        win_idx = i_idx[r];
        win_xyz = i_xyz[r];
        ptr_nxt = (r == LAST) ? '0 : PW'(r + 1);
      end
    end
  end

  if (SIZE == (1 << IDX_W)) begin : g_pow2
    assign idx_ok = 1'b1;
  end else begin : g_npow2
    assign idx_ok = (win_idx < IDX_W'(SIZE));
  end

  assign do_wr = do_grant & idx_ok;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (|elig_c) begin
          do_grant = 1'b1;
          if (COOL_CYCLES > 0) begin
            state_nxt = COOL;
            cnt_nxt   = CNT_W'(COOL_CYCLES - 1);
          end
        end
      end
      COOL: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      o_gnt  <= '0;
      o_busy <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_busy <= (state_nxt == COOL);
      o_gnt  <= do_grant ? win_c : '0;
      o_err  <= do_grant & ~idx_ok;
      if (do_grant) ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned e = 0; e < SIZE; e++) ent[e] <= '0;
    end else if (do_wr) begin
      ent[win_idx] <= win_xyz;
    end
  end

  svi_if u_I [SIZE] ();

  for (genvar g = 0; g < SIZE; g++) begin : g_ent
    assign u_I[g].x = ent[g].x;
    assign u_I[g].y = ent[g].y;
    assign u_I[g].z = ent[g].z;
    assign o_x[g]   = u_I[g].x;
    assign o_y[g]   = u_I[g].y;
    assign o_z[g]   = u_I[g].z;
  end

`ifdef SVI_SCHED_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          o_wr_cnt <= '0;
    else if (do_wr && o_wr_cnt != 16'hFFFF) o_wr_cnt <= o_wr_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_svi_array_write_sched.sv
// Bench for svi_array_write_sched: three configurations against a behavioural model.
module tb_svi_array_write_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]      req  [3];
  logic [3:0][2:0] idx  [3];
  logic [3:0][2:0] xyz  [3];
  logic [3:0]      gnt  [3];
  logic            busy [3];
  logic            err  [3];
  logic [7:0]      ox   [3];
  logic [7:0]      oy   [3];
  logic [7:0]      oz   [3];
`ifdef SVI_SCHED_STATS_EN
  logic [15:0]     wrcnt [3];
`endif

  // Instance 0: SIZE 8, cooldown 1; instance 1: SIZE 8, back-to-back; instance 2: SIZE 6, cooldown 2.
  svi_array_write_sched #(.SIZE(8), .N_REQ(4), .COOL_CYCLES(1)) d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_idx(idx[0]), .i_xyz(xyz[0]),
    .o_gnt(gnt[0]), .o_busy(busy[0]), .o_err(err[0]),
    .o_x(ox[0]), .o_y(oy[0]), .o_z(oz[0])
`ifdef SVI_SCHED_STATS_EN
    , .o_wr_cnt(wrcnt[0])
`endif
  );
  svi_array_write_sched #(.SIZE(8), .N_REQ(4), .COOL_CYCLES(0)) d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_idx(idx[1]), .i_xyz(xyz[1]),
    .o_gnt(gnt[1]), .o_busy(busy[1]), .o_err(err[1]),
    .o_x(ox[1]), .o_y(oy[1]), .o_z(oz[1])
`ifdef SVI_SCHED_STATS_EN
    , .o_wr_cnt(wrcnt[1])
`endif
  );
  svi_array_write_sched #(.SIZE(6), .N_REQ(4), .COOL_CYCLES(2)) d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[2]), .i_idx(idx[2]), .i_xyz(xyz[2]),
    .o_gnt(gnt[2]), .o_busy(busy[2]), .o_err(err[2]),
    .o_x(ox[2][5:0]), .o_y(oy[2][5:0]), .o_z(oz[2][5:0])
`ifdef SVI_SCHED_STATS_EN
    , .o_wr_cnt(wrcnt[2])
`endif
  );

  int sz [3] = '{8, 8, 6};
  int cc [3] = '{1, 0, 2};

  // Model state: pointer, remaining cooldown cycles, last grant/error, entry contents, write count.
  int          m_ptr  [3];
  int          m_cool [3];
  logic [3:0]  m_gnt  [3];
  logic        m_err  [3];
  logic [2:0]  mem    [3][8];
  logic [15:0] m_cnt  [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      m_ptr[n] = 0; m_cool[n] = 0; m_gnt[n] = '0; m_err[n] = 1'b0; m_cnt[n] = '0;
      for (int e = 0; e < 8; e++) mem[n][e] = '0;
    end
  endtask

  task automatic model_edge();
    for (int n = 0; n < 3; n++) begin
      logic [3:0] elig;
      int w;
      int p;
      elig = req[n] & ~m_gnt[n];
      m_gnt[n] = '0;
      m_err[n] = 1'b0;
      if (m_cool[n] > 0) begin
        m_cool[n]--;
      end else if (elig != 4'd0) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          p = (m_ptr[n] + k) % 4;
          if (w < 0 && elig[p]) w = p;
        end
        m_gnt[n][w] = 1'b1;
        if (int'(idx[n][w]) < sz[n]) begin
          mem[n][idx[n][w]] = xyz[n][w];
          if (m_cnt[n] != 16'hFFFF) m_cnt[n]++;
        end else begin
          m_err[n] = 1'b1;
        end
        m_ptr[n]  = (w + 1) % 4;
        m_cool[n] = cc[n];
      end
    end
  endtask

  task automatic compare_all();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] ex, ey, ez, mask;
      ex = '0; ey = '0; ez = '0; mask = '0;
      for (int e = 0; e < sz[n]; e++) begin
        ex[e] = mem[n][e][2]; ey[e] = mem[n][e][1]; ez[e] = mem[n][e][0]; mask[e] = 1'b1;
      end
      chk($sformatf("gnt%0d", n), 32'(gnt[n]), 32'(m_gnt[n]));
      chk($sformatf("err%0d", n), 32'(err[n]), 32'(m_err[n]));
      chk($sformatf("busy%0d", n), 32'(busy[n]), 32'(m_cool[n] > 0));
      chk($sformatf("x%0d", n), 32'(ox[n] & mask), 32'(ex));
      chk($sformatf("y%0d", n), 32'(oy[n] & mask), 32'(ey));
      chk($sformatf("z%0d", n), 32'(oz[n] & mask), 32'(ez));
`ifdef SVI_SCHED_STATS_EN
      chk($sformatf("wrcnt%0d", n), 32'(wrcnt[n]), 32'(m_cnt[n]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_reqs();
    for (int n = 0; n < 3; n++) req[n] = '0;
  endtask

  logic [3:0] exp0 [9] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
  logic [3:0] exp1 [9] = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1};

  initial begin
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin req[n] = '0; idx[n] = '0; xyz[n] = '0; end
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_gnt", 32'(gnt[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_x", 32'(ox[0]), 32'h0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_busy", 32'(busy[0]), 32'h0);

    // Single write: entry 3 <= 3'b101
    req[0] = 4'b0001; idx[0][0] = 3'd3; xyz[0][0] = 3'b101;
    step();
    chk("sw_gnt", 32'(gnt[0]), 32'h1);
    chk("sw_x3", 32'(ox[0][3]), 32'h1);
    chk("sw_y3", 32'(oy[0][3]), 32'h0);
    chk("sw_z3", 32'(oz[0][3]), 32'h1);
    chk("sw_busy", 32'(busy[0]), 32'h1);
    req[0] = '0;
    step();
    chk("sw_busy_end", 32'(busy[0]), 32'h0);
    chk("sw_gnt_end", 32'(gnt[0]), 32'h0);

    // Reset while cooling down
    req[0] = 4'b0010; idx[0][1] = 3'd5; xyz[0][1] = 3'b111;
    step();
    chk("rc_busy", 32'(busy[0]), 32'h1);
    chk("rc_x5", 32'(ox[0][5]), 32'h1);
    rst_n = 1'b0;
    clear_reqs();
    model_reset();
    #1;
    chk("rc_clr_x", 32'(ox[0]), 32'h0);
    chk("rc_clr_busy", 32'(busy[0]), 32'h0);
    compare_all();
    step();
    rst_n = 1'b1;

    // Fairness (d0), back-to-back (d1), out-of-range index (d2)
    req[0] = 4'hF;
    for (int r = 0; r < 4; r++) begin idx[0][r] = 3'($urandom); xyz[0][r] = 3'($urandom); end
    req[1] = 4'b0011; idx[1][0] = 3'd1; xyz[1][0] = 3'b110; idx[1][1] = 3'd1; xyz[1][1] = 3'b011;
    req[2] = 4'b0100; idx[2][2] = 3'd7; xyz[2][2] = 3'b111;
    for (int s = 0; s < 9; s++) begin
      step();
      chk($sformatf("fair_gnt_s%0d", s), 32'(gnt[0]), 32'(exp0[s]));
      chk($sformatf("b2b_gnt_s%0d", s), 32'(gnt[1]), 32'(exp1[s]));
      chk($sformatf("b2b_busy_s%0d", s), 32'(busy[1]), 32'h0);
      if (s == 0) begin
        chk("oor_gnt", 32'(gnt[2]), 32'h4);
        chk("oor_err", 32'(err[2]), 32'h1);
        chk("oor_x", 32'(ox[2][5:0]), 32'h0);
        req[2] = '0;
      end
    end
    clear_reqs();
    step(); step(); step();

    // Randomised traffic following the requester protocol
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        clear_reqs();
        model_reset();
        step();
        rst_n = 1'b1;
      end
      for (int n = 0; n < 3; n++) begin
        for (int r = 0; r < 4; r++) begin
          if (req[n][r] && m_gnt[n][r]) begin
            if ($urandom_range(0, 1) == 0) req[n][r] = 1'b0;
            else begin idx[n][r] = 3'($urandom); xyz[n][r] = 3'($urandom); end
          end else if (!req[n][r] && $urandom_range(0, 9) < 3) begin
            req[n][r] = 1'b1; idx[n][r] = 3'($urandom); xyz[n][r] = 3'($urandom);
          end
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
